// File: rtl/router_flit_injector_pkg.sv
// ============================================================================
// router_flit_injector_pkg : shared router flit type, data width default and
//                            injector FSM states.  Rev 1.0
// ============================================================================
`default_nettype none

package router_flit_injector_pkg;

  localparam int DEF_FLIT_DATA_W = 32;

  typedef struct packed {
    logic                       valid;
    logic                       output_port_num;
    logic                       tail;
    logic [DEF_FLIT_DATA_W-1:0] data;
  } pkt_flit_t;

  typedef enum logic [1:0] {
    INJ_IDLE  = 2'd0,
    INJ_SEND  = 2'd1,
    INJ_DRAIN = 2'd2
  } inj_state_e;

endpackage

`default_nettype wire

// File: rtl/router_flit_injector.sv
// ============================================================================
// router_flit_injector : serialises descriptor + payload words into router
//   flits through a 1-entry buffer gated by fifo_full.
//   Optional ROUTER_INJ_STATS_EN adds saturating pkt_cnt / flit_cnt outputs.
//   Rev 1.0
// ============================================================================
`default_nettype none

module router_flit_injector
  import router_flit_injector_pkg::*;
#(
  parameter int FLIT_DATA_W = DEF_FLIT_DATA_W,
  parameter int LEN_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_dest,
  input  logic [LEN_W-1:0]       req_len,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic [FLIT_DATA_W-1:0] data,
  output pkt_flit_t              pkt_out,
  input  logic                   fifo_full,
  output logic                   busy
`ifdef ROUTER_INJ_STATS_EN
  ,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            flit_cnt
`endif
);

  inj_state_e             state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic                   dest_q, dest_d;
  logic                   buf_v_q, buf_v_d;
  logic                   buf_dest_q, buf_dest_d;
  logic                   buf_tail_q, buf_tail_d;
  logic [FLIT_DATA_W-1:0] buf_data_q, buf_data_d;
  logic                   issue;
  logic                   last_word;
  logic                   data_hs;

  assign issue     = buf_v_q & ~fifo_full;
  assign last_word = (rem_q == LEN_W'(1));
  assign busy      = (state_q != INJ_IDLE) | buf_v_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dest_d     = dest_q;
    buf_v_d    = buf_v_q;
    buf_dest_d = buf_dest_q;
    buf_tail_d = buf_tail_q;
    buf_data_d = buf_data_q;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    data_hs    = 1'b0;

    // An issued flit frees the buffer unless a new word reloads it below.
    if (issue) buf_v_d = 1'b0;

    unique case (state_q)
      INJ_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dest_d  = req_dest;
          rem_d   = (req_len == '0) ? LEN_W'(1) : req_len;
          state_d = INJ_SEND;
        end
      end
      INJ_SEND: begin
        data_ready = ~buf_v_q | issue;
        data_hs    = data_valid & data_ready;
        if (data_hs) begin
          buf_v_d    = 1'b1;
          buf_dest_d = dest_q;
          buf_data_d = data;
          buf_tail_d = last_word;
          rem_d      = rem_q - LEN_W'(1);
          if (last_word) state_d = INJ_DRAIN;
        end
      end
      INJ_DRAIN: begin
        if (issue) state_d = INJ_IDLE;
      end
      default: state_d = INJ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= INJ_IDLE;
      rem_q      <= '0;
      dest_q     <= 1'b0;
      buf_v_q    <= 1'b0;
      buf_dest_q <= 1'b0;
      buf_tail_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dest_q     <= dest_d;
      buf_v_q    <= buf_v_d;
      buf_dest_q <= buf_dest_d;
      buf_tail_q <= buf_tail_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Stale buffer contents are masked so an empty buffer shows all-zero fields.
  always_comb begin
    pkt_out       = '0;
    pkt_out.valid = issue;
    if (buf_v_q) begin
      pkt_out.output_port_num = buf_dest_q;
      pkt_out.tail            = buf_tail_q;
      pkt_out.data            = buf_data_q;
    end
  end

`ifdef ROUTER_INJ_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] flit_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else if (issue) begin
      if (flit_cnt_q != 16'hFFFF) flit_cnt_q <= flit_cnt_q + 16'd1;
      if (buf_tail_q && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_flit_injector.sv
// ============================================================================
// tb_router_flit_injector : randomized bench with a packet-level reference
//   model for router_flit_injector.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_router_flit_injector;
  import router_flit_injector_pkg::*;

  localparam int LEN_W = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_dest = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [DW-1:0] data = '0;
  pkt_flit_t     pkt_out;
  logic          fifo_full = 1'b0;
  logic          busy;
`ifdef ROUTER_INJ_STATS_EN
  logic [15:0]   pkt_cnt;
  logic [15:0]   flit_cnt;
`endif

  router_flit_injector #(.FLIT_DATA_W(DW), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .pkt_out    (pkt_out),
    .fifo_full  (fifo_full),
    .busy       (busy)
`ifdef ROUTER_INJ_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .flit_cnt   (flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             dest;
    logic [LEN_W-1:0] len;
  } desc_t;

  desc_t         dq[$];
  logic [DW-1:0] wq[$];
  pkt_flit_t     exp_q[$];
  int            issue_cyc[$];
  int            acc_flits = 0;
  int            iss_flits = 0;
  int            flits_m   = 0;
  int            tails_m   = 0;
  int            n_cmp     = 0;
  int            n_err     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue one packet: descriptor, its payload words and the flits it must yield.
  task automatic add_pkt(input logic dest, input int len, input int base);
    desc_t     d;
    pkt_flit_t f;
    int        n;
    d.dest = dest;
    d.len  = LEN_W'(len);
    dq.push_back(d);
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      f.valid           = 1'b1;
      f.output_port_num = dest;
      f.tail            = (i == n - 1);
      f.data            = (base != 0) ? DW'(base + i) : DW'($urandom);
      wq.push_back(f.data);
      exp_q.push_back(f);
    end
  endtask

  // Called at posedge+1; returns at a negedge.
  task automatic run(input int p_req, input int p_data, input int p_full,
                     input int stop_issued, input int budget);
    int        cyc = 0;
    int        got_here = 0;
    int        outst;
    pkt_flit_t e;
    issue_cyc.delete();
    while (cyc < budget &&
           !(dq.size() == 0 && wq.size() == 0 && exp_q.size() == 0 && acc_flits == iss_flits)) begin
      req_valid  = (dq.size() > 0) && ($urandom_range(99) < p_req);
      if (dq.size() > 0) begin
        req_dest = dq[0].dest;
        req_len  = dq[0].len;
      end
      data_valid = (wq.size() > 0) && ($urandom_range(99) < p_data);
      if (wq.size() > 0) data = wq[0];
      fifo_full  = ($urandom_range(99) < p_full);
      @(negedge clk);
      outst = acc_flits - iss_flits;
      check_eq("busy", 64'(busy), 64'(outst > 0));
      check_eq("req_ready", 64'(req_ready), 64'(outst == 0));
      if (outst == 0) check_eq("data_ready_idle", 64'(data_ready), 64'd0);
      if (fifo_full) check_eq("valid_under_full", 64'(pkt_out.valid), 64'd0);
      if (pkt_out.valid) begin
        if (exp_q.size() == 0) begin
          check_eq("flit_extra", 64'(pkt_out), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("flit", 64'(pkt_out), 64'(e));
          tails_m += e.tail ? 1 : 0;
        end
        iss_flits++;
        flits_m++;
        got_here++;
        issue_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) begin
        acc_flits += (dq[0].len == 0) ? 1 : int'(dq[0].len);
        void'(dq.pop_front());
      end
      if (data_valid && data_ready) void'(wq.pop_front());
      if (stop_issued > 0 && got_here >= stop_issued) return;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= budget) check_eq("timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_data_ready"}, 64'(data_ready), 64'd0);
    check_eq({tag, "_pkt_out"}, 64'(pkt_out), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    pkt_flit_t f1;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_b = 1'b1;

    // Single 1-flit packet with cycle-exact timing
    req_valid = 1'b1; req_dest = 1'b1; req_len = 4'd1;
    data_valid = 1'b1; data = 32'hA5; fifo_full = 1'b0;
    @(negedge clk);
    check_eq("one_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check_eq("one_req_ready_busy", 64'(req_ready), 64'd0);
    check_eq("one_data_ready", 64'(data_ready), 64'd1);
    check_eq("one_no_flit_yet", 64'(pkt_out.valid), 64'd0);
    @(posedge clk); #1; data_valid = 1'b0;
    @(negedge clk);
    f1.valid = 1'b1; f1.output_port_num = 1'b1; f1.tail = 1'b1; f1.data = 32'hA5;
    check_eq("one_flit", 64'(pkt_out), 64'(f1));
    check_eq("one_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("one_busy_fall", 64'(busy), 64'd0);
    check_eq("one_pkt_out_clear", 64'(pkt_out), 64'd0);
    flits_m = 1; tails_m = 1;
    @(posedge clk); #1;

    // 4-flit packet, continuous data, no backpressure: 1 flit/cycle
    add_pkt(1'b0, 4, 1);
    run(100, 100, 0, 0, 100);
    check_eq("thru_count", 64'(issue_cyc.size()), 64'd4);
    if (issue_cyc.size() >= 4)
      check_eq("thru_span", 64'(issue_cyc[3] - issue_cyc[0]), 64'd3);
    @(posedge clk); #1;

    // len=0 followed by a second descriptor held until the tail issues
    add_pkt(1'b1, 0, 0);
    add_pkt(1'b0, 3, 0);
    run(100, 100, 40, 0, 200);
    @(posedge clk); #1;

    // Reset after flit 2 of 5
    add_pkt(1'b1, 5, 0);
    run(100, 100, 0, 2, 200);
    #1 rst_b = 1'b0;
    #1 check_reset_outputs("midrst");
`ifdef ROUTER_INJ_STATS_EN
    check_eq("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_eq("midrst_flit_cnt", 64'(flit_cnt), 64'd0);
`endif
    dq.delete(); wq.delete(); exp_q.delete();
    acc_flits = 0; iss_flits = 0; flits_m = 0; tails_m = 0;
    req_valid = 1'b0; data_valid = 1'b0; fifo_full = 1'b0;
    @(posedge clk); #1; rst_b = 1'b1;
    @(posedge clk); #1;

    // Packets of lengths 2, 3, 1 after reset
    add_pkt(1'b0, 2, 0);
    add_pkt(1'b1, 3, 0);
    add_pkt(1'b0, 1, 0);
    run(80, 80, 20, 0, 300);
`ifdef ROUTER_INJ_STATS_EN
    check_eq("stats_pkt_cnt", 64'(pkt_cnt), 64'd3);
    check_eq("stats_flit_cnt", 64'(flit_cnt), 64'd6);
`endif
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 30; i++)
      add_pkt(1'($urandom_range(1)), ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15)), 0);
    run(70, 80, 30, 0, 6000);
    check_eq("exp_drained", 64'(exp_q.size()), 64'd0);
`ifdef ROUTER_INJ_STATS_EN
    check_eq("final_pkt_cnt", 64'(pkt_cnt), 64'(tails_m));
    check_eq("final_flit_cnt", 64'(flit_cnt), 64'(flits_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
